// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input conditioning path.
package gpio_pkg;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;
    localparam int unsigned CORE_CLK_HZ           = 50_000_000;
    localparam int unsigned GPIO_IN_WIDTH         = 16;

endpackage

// File: rtl/gpio_in_debounce_if.sv
// Switch-bank input bus: raw pins and interrupt control in, clean levels/pulses/pending out.
interface gpio_in_debounce_if
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH = GPIO_IN_WIDTH
);

    logic [WIDTH-1:0] raw_i;
    logic [WIDTH-1:0] irq_en_i;
    logic [WIDTH-1:0] irq_clear_i;
    logic [WIDTH-1:0] db_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic [WIDTH-1:0] pend_o;
    logic             irq_o;

    modport master (
        output raw_i, irq_en_i, irq_clear_i,
        input  db_o, rise_o, fall_o, pend_o, irq_o
    );

    modport slave (
        input  raw_i, irq_en_i, irq_clear_i,
        output db_o, rise_o, fall_o, pend_o, irq_o
    );

endinterface

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchroniser, stable-time counter, debounced level and edge pulses.
module debounce_bit
    import gpio_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             db_q,    db_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    // Any return to the current level restarts the window, so short glitches never reach db.
    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            db_d   = sync2_q;
            rise_d = sync2_q;
            fall_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// Switch-bank input conditioner: per-bit debounce plus sticky change-pending bits and one interrupt.
module gpio_in_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH         = GPIO_IN_WIDTH,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    gpio_in_debounce_if.slave    bus
);

    logic [WIDTH-1:0] db_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] set_c;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             irq_q,  irq_d;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (bus.raw_i[i]),
            .db_o   (db_w[i]),
            .rise_o (rise_w[i]),
            .fall_o (fall_w[i])
        );
    end

    // Set wins over a simultaneous clear; disabling a bit leaves its pending state alone.
    always_comb begin
        set_c  = (rise_w | fall_w) & bus.irq_en_i;
        pend_d = set_c | (pend_q & ~bus.irq_clear_i);
        irq_d  = |pend_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    assign bus.db_o   = db_w;
    assign bus.rise_o = rise_w;
    assign bus.fall_o = fall_w;
    assign bus.pend_o = pend_q;
    assign bus.irq_o  = irq_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Scoreboard bench for gpio_in_debounce with WIDTH=16, STABLE_CYCLES=4.
module tb_gpio_in_debounce;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] pend;
        logic         irq;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    gpio_in_debounce_if #(.WIDTH(W)) bus ();

    gpio_in_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [W-1:0] db, input logic [W-1:0] rise,
                          input logic [W-1:0] fall, input logic [W-1:0] pend, input logic irq);
        exp_t e;
        e.db = db; e.rise = rise; e.fall = fall; e.pend = pend; e.irq = irq;
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e, obs;
        reset = 1'b1;
        bus.raw_i = 16'hFFFF; bus.irq_en_i = 16'hFFFF; bus.irq_clear_i = '0;
        push_n(3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_hold cyc%0d got %h exp %h", i, obs, e); end
        end
        reset = 1'b0;
        push_n(5, 0, 0, 0, 0, 0);
        push_n(1, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        push_n(2, 16'hFFFF, 0, 0, 16'hFFFF, 1);
        for (int i = 0; i < 8; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_release cyc%0d got %h exp %h", i, obs, e); end
        end
        // Return every channel to 0 and clear pending.
        bus.irq_en_i = '0; bus.irq_clear_i = 16'hFFFF; bus.raw_i = '0;
        push_n(5, 16'hFFFF, 0, 0, 0, 0);
        push_n(1, 0, 0, 16'hFFFF, 0, 0);
        push_n(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_cleanup cyc%0d got %h exp %h", i, obs, e); end
        end
        bus.irq_clear_i = '0;
    endtask

    task automatic test_single_rise();
        exp_t e, obs;
        bus.irq_en_i = '0; bus.raw_i = 16'h0008;
        push_n(5, 0, 0, 0, 0, 0);
        push_n(1, 16'h0008, 16'h0008, 0, 0, 0);
        push_n(2, 16'h0008, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL single_rise cyc%0d got %h exp %h", i, obs, e); end
        end
        bus.raw_i = '0;
        push_n(5, 16'h0008, 0, 0, 0, 0);
        push_n(1, 0, 0, 16'h0008, 0, 0);
        push_n(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL single_fall cyc%0d got %h exp %h", i, obs, e); end
        end
    endtask

    task automatic test_bounce();
        exp_t e, obs;
        int   seg_len [4] = '{3, 2, 3, 8};
        logic seg_val [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int s = 0; s < 4; s++) begin
            bus.raw_i = {15'h0, seg_val[s]};
            push_n(seg_len[s], 0, 0, 0, 0, 0);
            for (int i = 0; i < seg_len[s]; i++) begin
                step(); e = sb_q.pop_front();
                obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
                n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL bounce seg%0d cyc%0d got %h exp %h", s, i, obs, e); end
            end
        end
    endtask

    task automatic test_pend_set_clear();
        exp_t e, obs;
        bus.irq_en_i = 16'h0020; bus.raw_i = 16'h0020;
        push_n(5, 0, 0, 0, 0, 0);
        push_n(1, 16'h0020, 16'h0020, 0, 0, 0);
        push_n(1, 16'h0020, 0, 0, 16'h0020, 1);
        for (int i = 0; i < 7; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL pend_set cyc%0d got %h exp %h", i, obs, e); end
        end
        bus.irq_en_i = '0;
        push_n(2, 16'h0020, 0, 0, 16'h0020, 1);
        for (int i = 0; i < 2; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL pend_en_off cyc%0d got %h exp %h", i, obs, e); end
        end
        bus.irq_en_i = 16'h0020; bus.raw_i = '0;
        push_n(5, 16'h0020, 0, 0, 16'h0020, 1);
        push_n(1, 0, 0, 16'h0020, 16'h0020, 1);
        for (int i = 0; i < 6; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL pend_fall cyc%0d got %h exp %h", i, obs, e); end
        end
        // Clear while fall_o[5] is high: set wins, then the lone clear takes effect.
        bus.irq_clear_i = 16'h0020;
        push_n(1, 0, 0, 0, 16'h0020, 1);
        push_n(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL pend_clear cyc%0d got %h exp %h", i, obs, e); end
        end
        bus.irq_clear_i = '0; bus.irq_en_i = '0;
    endtask

    task automatic test_reset_mid_count();
        exp_t e, obs;
        bus.raw_i = 16'h0080;
        push_n(3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL midrst_pre cyc%0d got %h exp %h", i, obs, e); end
        end
        reset = 1'b1;
        push_n(2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL midrst_hold cyc%0d got %h exp %h", i, obs, e); end
        end
        reset = 1'b0;
        push_n(5, 0, 0, 0, 0, 0);
        push_n(1, 16'h0080, 16'h0080, 0, 0, 0);
        push_n(1, 16'h0080, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL midrst_post cyc%0d got %h exp %h", i, obs, e); end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e, obs;
        bus.raw_i = 16'h00F0;
        push_n(5, 16'h0080, 0, 0, 0, 0);
        push_n(1, 16'h00F0, 16'h0070, 0, 0, 0);
        push_n(1, 16'h00F0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL simul_rise cyc%0d got %h exp %h", i, obs, e); end
        end
        bus.raw_i = '0;
        push_n(5, 16'h00F0, 0, 0, 0, 0);
        push_n(1, 0, 0, 16'h00F0, 0, 0);
        push_n(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(); e = sb_q.pop_front();
            obs = '{bus.db_o, bus.rise_o, bus.fall_o, bus.pend_o, bus.irq_o};
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL simul_fall cyc%0d got %h exp %h", i, obs, e); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.raw_i = '0; bus.irq_en_i = '0; bus.irq_clear_i = '0;
        test_reset();
        test_single_rise();
        test_bounce();
        test_pend_set_clear();
        test_reset_mid_count();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
